boreal_pio_master: RTL and testbench
====================================

BOREAL_PIO_MASTER -- requirements
Module: boreal_pio_master

Interface
REQ-001 SHALL have parameter CMD_DEPTH, default 4, command FIFO entries (power of 2, range 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum cycles sel is held awaiting ack (range 1..255).
REQ-003 SHALL have parameter ADDR_LIMIT, default 32'h0000_0400, exclusive upper bound of the legal byte address.
REQ-004 SHALL have port: clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: cmd_valid input 1, cmd_ready output 1  command handshake.
REQ-007 SHALL have ports: cmd_wr input 1, cmd_addr input 32, cmd_wdata input 32  command payload (1 = write, 0 = read).
REQ-008 SHALL have ports: rsp_valid output 1, rsp_ready input 1  response handshake.
REQ-009 SHALL have ports: rsp_rdata output 32 (read data, else 0); rsp_code output 2 (00 OK, 01 bad address, 10 timeout, 11 verify mismatch).
REQ-010 SHALL have ports: sel output 1, wr output 1, addr output 32, wdata output 32  bus request to the privileged register slave, all registered.
REQ-011 SHALL have ports: rdata input 32, ack input 1  bus response from the slave; ack may be combinational from sel.
REQ-012 SHALL have port: busy output 1  high when FIFO non-empty or FSM not IDLE.

Function
REQ-013 SHALL accept a command on a rising edge with cmd_valid && cmd_ready; cmd_ready = FIFO not full, combinational from FIFO state only.
REQ-014 SHALL execute commands strictly in order, one outstanding bus transaction maximum.
REQ-015 SHALL implement FSM states IDLE, CHECK, REQ, VERIFY, RESP.
REQ-016 IDLE -> CHECK when FIFO non-empty and no response pending; head entry popped into a working register on that edge.
REQ-017 CHECK: if addr[1:0] != 0 or addr >= ADDR_LIMIT -> RESP with code 01, no bus cycle; else -> REQ, driving sel=1, wr, addr, wdata from the next edge.
REQ-018 REQ: on any edge with ack=1, capture rdata (reads) or 0 (writes), deassert sel, -> VERIFY if the feature is compiled in and wr=1, else -> RESP with code 00.
REQ-019 REQ: timeout counter resets on REQ entry and increments each REQ cycle without ack; at count == TIMEOUT, deassert sel -> RESP, code 10, rsp_rdata 0.
REQ-020 With slave ack = sel, command acceptance to rsp_valid SHALL be 4 cycles for a read or unverified write (FIFO write, CHECK, REQ, RESP).
REQ-021 RESP: rsp_valid=1; rsp_rdata and rsp_code SHALL hold stable until rsp_ready; on rsp_valid && rsp_ready -> IDLE.
REQ-022 A back-to-back command SHALL enter CHECK on the edge after the response handshake; no bus cycle overlaps RESP.
REQ-023 Simultaneous push and pop on the same edge SHALL be supported when FIFO full; the entry freed by the pop is not reused for the push on that edge (cmd_ready low while full).
REQ-024 FIFO pointers SHALL wrap modulo CMD_DEPTH; occupancy count width clog2(CMD_DEPTH)+1.
REQ-025 sel and wr SHALL never be high outside REQ/VERIFY; wdata SHALL be 0 when wr=0.

Reset
REQ-026 On rst_n low, asynchronously: FSM IDLE, FIFO empty, sel=0, wr=0, addr=0, wdata=0, rsp_valid=0, rsp_rdata=0, rsp_code=00, timeout counter 0.
REQ-027 Reset mid-transaction SHALL abort it with no response and discard all queued commands; busy=0 after reset.
REQ-028 cmd_ready SHALL be 1 during and after reset (FIFO empty).

Configuration
REQ-029 Macro BOREAL_PIO_WRITE_VERIFY_EN defined: after each write ack, VERIFY issues a read (sel=1, wr=0) to the same addr with TIMEOUT rules; readback != written data -> code 11, timeout -> code 10, match -> code 00 with rsp_rdata = readback.
REQ-030 Macro absent: VERIFY state and its compare logic not synthesized; writes complete with code 00 on first ack.

Verification
REQ-031 Write 0x10 data 0xDEADBEEF, slave ack=sel -> one sel&wr cycle addr 0x10, rsp_code 00, rsp_valid 4 cycles after accept.
REQ-032 Read 0x10 after the above -> rsp_rdata 0xDEADBEEF, code 00.
REQ-033 Commands addr 0x402 and 0x400 -> code 01 each, sel never asserted.
REQ-034 Slave ack tied 0, TIMEOUT=16 -> sel high exactly 16 cycles, code 10, rsp_rdata 0.
REQ-035 Push 5 commands with rsp_ready=0, CMD_DEPTH=4 -> cmd_ready low after 4th accepted while the first sits in CHECK/RESP; all 5 responses return in order once rsp_ready=1.
REQ-036 With BOREAL_PIO_WRITE_VERIFY_EN, slave returns rdata 0x0 on readback after writing 0x55 -> code 11; rst_n pulsed during REQ -> sel drops immediately, no rsp_valid.

Source files
------------

// File: rtl/boreal_pio_master.sv
// boreal_pio_master: queued PIO master for the privileged register slave.
// Commands are buffered in a small FIFO, range-checked, then executed one at
// a time as a single-beat sel/ack bus cycle with a bounded wait for ack.
// Optional feature macro: BOREAL_PIO_WRITE_VERIFY_EN (read-back check of
// every write; writes report 11 on readback mismatch).
module boreal_pio_master #(
   parameter int unsigned CMD_DEPTH  = 4,
   parameter int unsigned TIMEOUT    = 16,
   parameter logic [31:0] ADDR_LIMIT = 32'h0000_0400
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_wr,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_code,
   output logic        sel,
   output logic        wr,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   input  logic [31:0] rdata,
   input  logic        ack,
   output logic        busy
);

   localparam int unsigned AW = $clog2(CMD_DEPTH);
   localparam int unsigned CW = $clog2(CMD_DEPTH) + 1;
   localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

   localparam logic [1:0] CODE_OK   = 2'b00;
   localparam logic [1:0] CODE_ADDR = 2'b01;
   localparam logic [1:0] CODE_TO   = 2'b10;
`ifdef BOREAL_PIO_WRITE_VERIFY_EN
   localparam logic [1:0] CODE_MIS  = 2'b11;
`endif

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      REQ,
`ifdef BOREAL_PIO_WRITE_VERIFY_EN
      VERIFY,
`endif
      RESP
   } state_t;

   state_t state;

   logic [64:0]   fifo_mem [CMD_DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [CW-1:0] count;
   logic          fifo_empty;
   logic          push;
   logic          pop;

   logic [7:0]    tcnt;
   logic          w_wr;
   logic [31:0]   w_addr;
   logic [31:0]   w_wdata;

   assign fifo_empty = (count == '0);
   assign cmd_ready  = (count != CW'(CMD_DEPTH));
   assign push       = cmd_valid && cmd_ready;
   assign pop        = (state == IDLE) && !fifo_empty && !rsp_valid;
   assign busy       = !fifo_empty || (state != IDLE);

   // Command storage; no reset needed, validity is tracked by count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wp] <= {cmd_wr, cmd_addr, cmd_wdata};
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at CMD_DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + AW'(1);
         if (pop)  rp <= rp + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Control FSM with registered bus and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sel       <= 1'b0;
         wr        <= 1'b0;
         addr      <= '0;
         wdata     <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_code  <= CODE_OK;
         tcnt      <= '0;
         w_wr      <= 1'b0;
         w_addr    <= '0;
         w_wdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  {w_wr, w_addr, w_wdata} <= fifo_mem[rp];
                  state <= CHECK;
               end
            end

            CHECK: begin
               if ((w_addr[1:0] != 2'b00) || (w_addr >= ADDR_LIMIT)) begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= '0;
                  rsp_code  <= CODE_ADDR;
                  state     <= RESP;
               end else begin
                  sel   <= 1'b1;
                  wr    <= w_wr;
                  addr  <= w_addr;
                  wdata <= w_wr ? w_wdata : '0;
                  tcnt  <= '0;
                  state <= REQ;
               end
            end

            REQ: begin
               if (ack) begin
                  sel   <= 1'b0;
                  wr    <= 1'b0;
                  wdata <= '0;
`ifdef BOREAL_PIO_WRITE_VERIFY_EN
                  if (wr) begin
                     // addr is kept so VERIFY can re-issue it as a read
                     tcnt  <= '0;
                     state <= VERIFY;
                  end else begin
                     addr      <= '0;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= rdata;
                     rsp_code  <= CODE_OK;
                     state     <= RESP;
                  end
`else
                  addr      <= '0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= wr ? '0 : rdata;
                  rsp_code  <= CODE_OK;
                  state     <= RESP;
`endif
               end else if (tcnt == TO_LAST) begin
                  sel       <= 1'b0;
                  wr        <= 1'b0;
                  addr      <= '0;
                  wdata     <= '0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= '0;
                  rsp_code  <= CODE_TO;
                  state     <= RESP;
               end else begin
                  tcnt <= tcnt + 8'd1;
               end
            end

`ifdef BOREAL_PIO_WRITE_VERIFY_EN
            VERIFY: begin
               // first VERIFY cycle has sel low; the read-back starts on its edge
               if (!sel) begin
                  sel  <= 1'b1;
                  tcnt <= '0;
               end else if (ack) begin
                  sel       <= 1'b0;
                  addr      <= '0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= rdata;
                  rsp_code  <= (rdata == w_wdata) ? CODE_OK : CODE_MIS;
                  state     <= RESP;
               end else if (tcnt == TO_LAST) begin
                  sel       <= 1'b0;
                  addr      <= '0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= '0;
                  rsp_code  <= CODE_TO;
                  state     <= RESP;
               end else begin
                  tcnt <= tcnt + 8'd1;
               end
            end
`endif

            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_code  <= CODE_OK;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_boreal_pio_master.sv
// Bench for boreal_pio_master: directed commands against a word-array slave,
// expected responses computed from the command rules and a shadow memory.
module tb_boreal_pio_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_wr;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_code;
   logic        sel;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;
   logic        busy;

   logic        ack_en;
   logic        corrupt;
   logic [31:0] smem [256];
   logic [31:0] mmem [256];

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [1:0]  code;
   } exp_t;

   exp_t        q[$];
   int          ntests;
   int          nfail;
   int          sel_cycles;
   int          rsp_count;
   logic [31:0] last_rdata;
   logic [1:0]  last_code;

   always #5 clk = ~clk;

   boreal_pio_master #(
      .CMD_DEPTH (4),
      .TIMEOUT   (16),
      .ADDR_LIMIT(32'h0000_0400)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_wr   (cmd_wr),
      .cmd_addr (cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_code (rsp_code),
      .sel      (sel),
      .wr       (wr),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .ack      (ack),
      .busy     (busy)
   );

   // Slave: combinational ack from sel, word memory cleared while in reset.
   assign ack   = sel & ack_en;
   assign rdata = corrupt ? 32'h0 : smem[addr[9:2]];

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) smem[i] <= 32'h0;
      end else if (sel && ack && wr) begin
         smem[addr[9:2]] <= wdata;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_model();
      q.delete();
      for (int i = 0; i < 256; i++) mmem[i] = 32'h0;
   endtask

   // Issue one command, wait (bounded) for acceptance, and queue its expected response.
   task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      bit   acc;
      logic [31:0] rb;
      e.wr = w;
      e.addr = a;
      e.wdata = d;
      if ((a % 4) != 0 || a >= 32'h400) begin
         e.code = 2'd1;
         e.rdata = 32'h0;
      end else if (!ack_en) begin
         e.code = 2'd2;
         e.rdata = 32'h0;
      end else if (w) begin
         mmem[a / 4] = d;
`ifdef BOREAL_PIO_WRITE_VERIFY_EN
         rb = corrupt ? 32'h0 : d;
         e.code = (rb == d) ? 2'd0 : 2'd3;
         e.rdata = rb;
`else
         rb = 32'h0;
         e.code = 2'd0;
         e.rdata = rb;
`endif
      end else begin
         e.code = 2'd0;
         e.rdata = corrupt ? 32'h0 : mmem[a / 4];
      end
      cmd_valid = 1'b1;
      cmd_wr = w;
      cmd_addr = a;
      cmd_wdata = d;
      acc = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         acc = cmd_ready;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      cmd_valid = 1'b0;
      cmd_wr = 1'b0;
      cmd_addr = 32'h0;
      cmd_wdata = 32'h0;
      check("cmd_accept", {31'h0, acc}, 32'h1);
      if (acc) q.push_back(e);
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (q.size() == 0 && !busy && !rsp_valid) begin
            done = 1'b1;
            break;
         end
      end
      check("idle_wait", {31'h0, done}, 32'h1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int s0;
      int r0;
      bit seen;
      ntests = 0;
      nfail = 0;
      sel_cycles = 0;
      rsp_count = 0;
      last_rdata = 32'h0;
      last_code = 2'd0;
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_wr = 1'b0;
      cmd_addr = 32'h0;
      cmd_wdata = 32'h0;
      rsp_ready = 1'b1;
      ack_en = 1'b1;
      corrupt = 1'b0;
      clear_model();

      // Compare process: bus/response checks against the model on every cycle.
      fork
         begin
            bit          hold;
            logic [31:0] prev_rdata;
            logic [1:0]  prev_code;
            hold = 1'b0;
            prev_rdata = 32'h0;
            prev_code = 2'd0;
            forever begin
               @(negedge clk);
               if (!rst_n) begin
                  hold = 1'b0;
                  continue;
               end
               if (wr) check("wr_without_sel", {31'h0, sel}, 32'h1);
               if (!wr) check("wdata_when_read", wdata, 32'h0);
               if (sel) begin
                  sel_cycles++;
                  check("bus_during_resp", {31'h0, rsp_valid}, 32'h0);
                  if (q.size() == 0) begin
                     check("bus_unexpected", q.size(), 1);
                  end else begin
                     check("bus_addr", addr, q[0].addr);
`ifdef BOREAL_PIO_WRITE_VERIFY_EN
                     if (wr) check("bus_wr_cmd", {31'h0, q[0].wr}, 32'h1);
`else
                     check("bus_wr", {31'h0, wr}, {31'h0, q[0].wr});
`endif
                     if (wr) check("bus_wdata", wdata, q[0].wdata);
                  end
               end
               if (hold) begin
                  check("rsp_rdata_stable", rsp_rdata, prev_rdata);
                  check("rsp_code_stable", {30'h0, rsp_code}, {30'h0, prev_code});
               end
               if (rsp_valid && rsp_ready) begin
                  if (q.size() == 0) begin
                     check("rsp_unexpected", q.size(), 1);
                  end else begin
                     check("rsp_rdata", rsp_rdata, q[0].rdata);
                     check("rsp_code", {30'h0, rsp_code}, {30'h0, q[0].code});
                     void'(q.pop_front());
                  end
                  last_rdata = rsp_rdata;
                  last_code = rsp_code;
                  rsp_count++;
               end
               hold = rsp_valid && !rsp_ready;
               prev_rdata = rsp_rdata;
               prev_code = rsp_code;
            end
         end
      join_none

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
      check("rst_sel", {31'h0, sel}, 32'h0);
      check("rst_wr", {31'h0, wr}, 32'h0);
      check("rst_addr", addr, 32'h0);
      check("rst_wdata", wdata, 32'h0);
      check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_rsp_code", {30'h0, rsp_code}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Write 0x10 <= DEADBEEF: rsp_valid rises on the third edge after the accept edge
      s0 = sel_cycles;
      push(1'b1, 32'h10, 32'hDEAD_BEEF);
`ifndef BOREAL_PIO_WRITE_VERIFY_EN
      @(negedge clk) check("wr_lat_fifo", {31'h0, rsp_valid}, 32'h0);
      @(negedge clk) check("wr_lat_check", {31'h0, rsp_valid}, 32'h0);
      @(negedge clk) check("wr_lat_req", {31'h0, rsp_valid}, 32'h0);
      @(negedge clk) check("wr_lat_resp", {31'h0, rsp_valid}, 32'h1);
`endif
      wait_idle();
`ifdef BOREAL_PIO_WRITE_VERIFY_EN
      check("wr_sel_cycles", sel_cycles - s0, 2);
`else
      check("wr_sel_cycles", sel_cycles - s0, 1);
`endif
      check("wr_code", {30'h0, last_code}, 32'h0);

      // Read back 0x10
      push(1'b0, 32'h10, 32'h0);
      @(negedge clk) check("rd_lat_fifo", {31'h0, rsp_valid}, 32'h0);
      @(negedge clk) check("rd_lat_check", {31'h0, rsp_valid}, 32'h0);
      @(negedge clk) check("rd_lat_req", {31'h0, rsp_valid}, 32'h0);
      @(negedge clk) check("rd_lat_resp", {31'h0, rsp_valid}, 32'h1);
      wait_idle();
      check("rd_rdata", last_rdata, 32'hDEAD_BEEF);
      check("rd_code", {30'h0, last_code}, 32'h0);

      // Illegal addresses: unaligned and at the limit, no bus cycle
      s0 = sel_cycles;
      push(1'b0, 32'h402, 32'h0);
      push(1'b1, 32'h400, 32'h5);
      wait_idle();
      check("bad_sel_cycles", sel_cycles - s0, 0);
      check("bad_code", {30'h0, last_code}, 32'h1);

      // Highest legal word
      push(1'b1, 32'h3FC, 32'h1234_5678);
      push(1'b0, 32'h3FC, 32'h0);
      wait_idle();
      check("top_rdata", last_rdata, 32'h1234_5678);

      // Timeout with ack stuck low
      ack_en = 1'b0;
      s0 = sel_cycles;
      push(1'b0, 32'h20, 32'h0);
      wait_idle();
      check("to_sel_cycles", sel_cycles - s0, 16);
      check("to_code", {30'h0, last_code}, 32'h2);
      check("to_rdata", last_rdata, 32'h0);
      ack_en = 1'b1;

      // Five back-to-back commands with the response stalled
      rsp_ready = 1'b0;
      r0 = rsp_count;
      push(1'b0, 32'h10, 32'h0);
      push(1'b1, 32'h40, 32'hA1A1_A1A1);
      push(1'b1, 32'h44, 32'hB2B2_B2B2);
      push(1'b0, 32'h401, 32'h0);
      push(1'b0, 32'h44, 32'h0);
      @(negedge clk);
      check("full_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      check("full_busy", {31'h0, busy}, 32'h1);
      check("full_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      @(negedge clk);
      check("full_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      wait_idle();
      check("burst_rsp_count", rsp_count - r0, 5);
      check("burst_last_rdata", last_rdata, 32'hB2B2_B2B2);

      // Reset during REQ with a second command queued
      ack_en = 1'b0;
      r0 = rsp_count;
      push(1'b0, 32'h30, 32'h0);
      push(1'b1, 32'h34, 32'h7);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (sel) begin
            seen = 1'b1;
            break;
         end
      end
      check("abort_sel_seen", {31'h0, seen}, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_sel", {31'h0, sel}, 32'h0);
      check("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      check("abort_busy", {31'h0, busy}, 32'h0);
      check("abort_cmd_ready", {31'h0, cmd_ready}, 32'h1);
      clear_model();
      ack_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      s0 = sel_cycles;
      repeat (10) @(posedge clk);
      #1;
      check("abort_no_rsp", rsp_count - r0, 0);
      check("abort_no_bus", sel_cycles - s0, 0);
      check("abort_idle", {31'h0, busy}, 32'h0);
      push(1'b1, 32'h8, 32'hCAFE_F00D);
      push(1'b0, 32'h8, 32'h0);
      wait_idle();
      check("post_rst_rdata", last_rdata, 32'hCAFE_F00D);

`ifdef BOREAL_PIO_WRITE_VERIFY_EN
      // Read-back returns 0 after writing 0x55
      corrupt = 1'b1;
      push(1'b1, 32'h50, 32'h55);
      wait_idle();
      check("verify_mismatch_code", {30'h0, last_code}, 32'h3);
      corrupt = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
